signed_alu_arbiter: RTL and testbench
=====================================

Name: signed_alu_arbiter

Overview:
- Shares one registered signed arithmetic unit (add, sub, mul, div) among NUM_REQ requesters using round-robin arbitration.
- Each requester presents an opcode and two signed operands over a valid/ready handshake.
- The arbiter grants one requester, runs the operation, then holds a tagged result until the consumer accepts it.
- Sits between the MATH-example stimulus sources and the result sink/display logic.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, signed operand width
ID_W, 2, requester index width; must equal clog2(NUM_REQ)

Ports:
clk  in  1  clock
n_rst  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
req_op  in  2*NUM_REQ  opcode per requester: 0 add, 1 sub, 2 mul, 3 div
req_a  in  DATA_W*NUM_REQ  signed operand A per requester, slice i = requester i
req_b  in  DATA_W*NUM_REQ  signed operand B per requester
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_id  out  ID_W  index of the requester that owns the result
rsp_op  out  2  opcode of the result
rsp_result  out  2*DATA_W  signed result, sign-extended
rsp_div0  out  1  division by zero flag
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
Reset (n_rst low, asynchronous):
- FSM goes to IDLE; rr_ptr = 0.
- All outputs are 0: req_ready, rsp_valid, rsp_id, rsp_op, rsp_result, rsp_div0, busy.
- Asserting reset mid-operation discards any in-flight operation; no response is produced for it.

FSM states:
- IDLE: req_ready is driven combinationally.
  - It is one-hot on the first asserted req_valid found searching from rr_ptr upward with wrap-around.
  - On the handshake cycle, operands, opcode and id are latched; rr_ptr = grant+1 mod NUM_REQ; next state EXEC.
  - No req_valid asserted: stay in IDLE; req_ready = 0.
- EXEC (exactly 1 cycle): signed_alu_core registers the result; next state RESP. req_ready = 0.
- RESP: rsp_valid = 1, and all rsp_* outputs stay stable until rsp_ready is sampled high.
  - On that cycle: rsp_valid falls next cycle; next state IDLE.
  - No new grant is issued in the same cycle as the rsp handshake.

Timing and throughput:
- Latency: request handshake at cycle N gives rsp_valid at cycle N+2, with rsp_ready held high.
- Peak throughput: one operation per 3 cycles.

Requester rules:
- A requester must hold its req_valid, op and operands stable until req_ready.
- Deasserting req_valid without a handshake is permitted; that requester is simply not granted.

Arithmetic (operands sign-extended to 2*DATA_W before the operation):
- add, sub: the full-precision result fits in DATA_W+1 bits; it is output sign-extended.
- mul: full 2*DATA_W signed product. Example: -128*-128 = 16384 = 0x4000, no overflow.
- div: truncation toward zero; remainder is discarded.
  - -128 / -1 = +128, fits in the wide result.
- B = 0 with div: rsp_result = 0, rsp_div0 = 1.
- rsp_div0 = 0 for every other case.

Fairness: a requester that holds req_valid continuously is granted within NUM_REQ grants.

Decomposition:
- Package signed_alu_pkg holds:
  - opcode constants OP_ADD = 0, OP_SUB = 1, OP_MUL = 2, OP_DIV = 3
  - FSM state encodings S_IDLE, S_EXEC, S_RESP
- Sub-module signed_alu_core:
  - inputs: clk, n_rst, en, op, a, b
  - outputs: registered result and div0
  - one-cycle latency; isolates the arithmetic from the arbitration logic.

Test Plan:
1. Single requester: req 1 issues add, A = 100, B = 27 -> rsp_result = 127, rsp_id = 1, rsp_valid exactly 2 cycles after the handshake.
2. Mul corner: A = -128, B = -128 -> rsp_result = 16384. Div corner: A = -128, B = -1 -> rsp_result = 128. Both with rsp_div0 = 0.
3. Divide by zero: A = 55, B = 0, op div -> rsp_result = 0, rsp_div0 = 1.
4. All four requesters valid continuously from reset -> grant order 0, 1, 2, 3, 0 and no repeat grant before the others are served.
5. Backpressure: rsp_ready held low for 5 cycles -> rsp_* stable, req_ready stays 0 throughout, no lost or duplicated response.
6. Reset asserted during EXEC -> all outputs 0 immediately; after release, rr_ptr = 0 and no stale response appears.

Source files
------------

// File: rtl/signed_alu_pkg.sv
// Shared opcode constants, FSM state encoding and a small index helper for the
// signed ALU arbiter slice.
package signed_alu_pkg;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Next index after idx in a ring of n entries; n need not be a power of two.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/signed_alu_core.sv
// Registered signed add/sub/mul/div on sign-extended operands. The result
// updates only when en is high and is otherwise held.
module signed_alu_core
    import signed_alu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  en,
    input  logic [1:0]            op,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic [2*DATA_W-1:0]   result,
    output logic                  div0
);

    localparam int RES_W = 2 * DATA_W;

    logic signed [RES_W-1:0] a_ext;
    logic signed [RES_W-1:0] b_ext;
    logic signed [RES_W-1:0] result_d;
    logic signed [RES_W-1:0] result_q;
    logic                    div0_d;
    logic                    div0_q;

    assign a_ext = {{DATA_W{a[DATA_W-1]}}, a};
    assign b_ext = {{DATA_W{b[DATA_W-1]}}, b};

    // At double width every product and the -MIN/-1 quotient fit exactly,
    // so no overflow handling is needed; the divider is kept off a zero divisor.
    always_comb begin
        result_d = result_q;
        div0_d   = div0_q;
        if (en) begin
            div0_d = 1'b0;
            case (op)
                OP_ADD:  result_d = a_ext + b_ext;
                OP_SUB:  result_d = a_ext - b_ext;
                OP_MUL:  result_d = a_ext * b_ext;
                OP_DIV: begin
                    if (b_ext == '0) begin
                        result_d = '0;
                        div0_d   = 1'b1;
                    end else begin
                        result_d = a_ext / b_ext;
                    end
                end
                default: result_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            result_q <= '0;
            div0_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            div0_q   <= div0_d;
        end
    end

    assign result = result_q;
    assign div0   = div0_q;

endmodule

// File: rtl/signed_alu_arbiter.sv
// Round-robin arbiter sharing one registered signed ALU among NUM_REQ
// requesters; each granted operation yields one tagged, held response.
module signed_alu_arbiter
    import signed_alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = 2
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [2*NUM_REQ-1:0]        req_op,
    input  logic [DATA_W*NUM_REQ-1:0]   req_a,
    input  logic [DATA_W*NUM_REQ-1:0]   req_b,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [ID_W-1:0]             rsp_id,
    output logic [1:0]                  rsp_op,
    output logic [2*DATA_W-1:0]         rsp_result,
    output logic                        rsp_div0,
    output logic                        busy
);

    state_t              state_q;
    state_t              state_d;
    logic [ID_W-1:0]     rr_ptr_q;
    logic [ID_W-1:0]     rr_ptr_d;
    logic [ID_W-1:0]     id_q;
    logic [ID_W-1:0]     id_d;
    logic [1:0]          op_q;
    logic [1:0]          op_d;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   a_d;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   b_d;

    logic [1:0]          op_arr [NUM_REQ];
    logic [DATA_W-1:0]   a_arr  [NUM_REQ];
    logic [DATA_W-1:0]   b_arr  [NUM_REQ];

    logic                grant_found;
    logic [ID_W-1:0]     grant_idx;
    logic                grant_en;
    logic                alu_en;

    // req_ready is combinational, so it is also qualified by n_rst to keep it
    // low while reset is held even if requesters are already valid.
    assign grant_en = n_rst && (state_q == S_IDLE) && grant_found;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign op_arr[gi]    = req_op[2*gi +: 2];
            assign a_arr[gi]     = req_a[DATA_W*gi +: DATA_W];
            assign b_arr[gi]     = req_b[DATA_W*gi +: DATA_W];
            assign req_ready[gi] = grant_en && (grant_idx == ID_W'(gi));
        end
    endgenerate

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        int scan_idx;
        scan_idx    = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(scan_idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        alu_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_en) begin
                    id_d     = grant_idx;
                    op_d     = op_arr[grant_idx];
                    a_d      = a_arr[grant_idx];
                    b_d      = b_arr[grant_idx];
                    rr_ptr_d = ID_W'(wrap_inc(int'(grant_idx), NUM_REQ));
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_en  = 1'b1;
                state_d = S_RESP;
            end
            S_RESP: begin
                // Returning to IDLE first keeps a new grant out of the
                // response-handshake cycle.
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
        end
    end

    signed_alu_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .clk    (clk),
        .n_rst  (n_rst),
        .en     (alu_en),
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (rsp_result),
        .div0   (rsp_div0)
    );

    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = id_q;
    assign rsp_op    = op_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_signed_alu_arbiter.sv
// Scoreboard bench: the driver predicts grants and results with plain integer
// arithmetic and queues them; an independent monitor checks each response.
module tb_signed_alu_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              n_rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [2*N-1:0]    req_op;
    logic [W*N-1:0]    req_a;
    logic [W*N-1:0]    req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [1:0]        rsp_op;
    logic [2*W-1:0]    rsp_result;
    logic              rsp_div0;
    logic              busy;

    signed_alu_arbiter #(.NUM_REQ(N), .DATA_W(W), .ID_W(IW)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_op     (rsp_op),
        .rsp_result (rsp_result),
        .rsp_div0   (rsp_div0),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int id;
        int op;
        int res;
        int d0;
        int hs_cyc;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];

    int tests_run    = 0;
    int tests_failed = 0;

    // requester-side model state
    bit         pend_valid [N];
    logic [1:0] pend_op    [N];
    logic [7:0] pend_a     [N];
    logic [7:0] pend_b     [N];
    int         wait_cnt   [N];
    int         model_ptr   = 0;
    bit         model_busy  = 0;
    int         grant_cyc   = 0;
    int         accept_cyc  = -1;
    int         hs_count    = 0;
    int         rsp_count   = 0;
    int         flushed     = 0;
    bit         auto_refill = 0;
    bit         bp_mode     = 0;

    task automatic chk(input string name, input int act, input int expv);
        tests_run++;
        if (act != expv) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int model_result(input int op, input int a, input int b);
        case (op)
            0:       return a + b;
            1:       return a - b;
            2:       return a * b;
            default: return (b == 0) ? 0 : a / b;
        endcase
    endfunction

    function automatic logic [7:0] pick_operand();
        logic [7:0] v;
        if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 3))
                0:       v = 8'h80;
                1:       v = 8'hFF;
                2:       v = 8'h00;
                default: v = 8'h7F;
            endcase
        end else begin
            v = 8'($urandom);
        end
        return v;
    endfunction

    task automatic set_req(input int i, input int op, input int a, input int b);
        pend_valid[i] = 1'b1;
        pend_op[i]    = 2'(op);
        pend_a[i]     = 8'(a);
        pend_b[i]     = 8'(b);
        wait_cnt[i]   = 0;
    endtask

    task automatic new_random_req(input int i);
        set_req(i, $urandom_range(0, 3), int'(pick_operand()), int'(pick_operand()));
    endtask

    // One cycle: drive at posedge+1, predict and observe at negedge.
    task automatic step();
        int   exp_g;
        int   idx;
        int   g;
        int   maxw;
        logic [N-1:0] exp_ready;
        exp_t e;
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = pend_valid[i];
            req_op[2*i +: 2]   = pend_op[i];
            req_a[W*i +: W]    = pend_a[i];
            req_b[W*i +: W]    = pend_b[i];
        end
        @(negedge clk);
        if (model_busy && accept_cyc > grant_cyc && accept_cyc < cyc) model_busy = 0;
        exp_g = -1;
        for (int k = 0; k < N; k++) begin
            idx = (model_ptr + k) % N;
            if (exp_g < 0 && pend_valid[idx]) exp_g = idx;
        end
        exp_ready = (!model_busy && exp_g >= 0) ? N'(1 << exp_g) : '0;
        chk("busy", int'(busy), int'(model_busy));
        chk("req_ready", int'(req_ready), int'(exp_ready));
        if ((req_ready & req_valid) != '0) begin
            g = 0;
            for (int i = N - 1; i >= 0; i--) if (req_ready[i]) g = i;
            e.id     = g;
            e.op     = int'(pend_op[g]);
            e.res    = model_result(e.op, int'($signed(pend_a[g])), int'($signed(pend_b[g])));
            e.d0     = (e.op == 3 && pend_b[g] == 8'h00) ? 1 : 0;
            e.hs_cyc = cyc;
            sb.push_back(e);
            maxw = 0;
            for (int i = 0; i < N; i++) begin
                if (i != g && pend_valid[i]) begin
                    wait_cnt[i]++;
                    if (wait_cnt[i] > maxw) maxw = wait_cnt[i];
                end
            end
            chk("fair_wait_le_N-1", int'(maxw <= N - 1), 1);
            model_ptr     = (g + 1) % N;
            model_busy    = 1;
            grant_cyc     = cyc;
            pend_valid[g] = 1'b0;
            wait_cnt[g]   = 0;
            grant_log.push_back(g);
            hs_count++;
            if (auto_refill) new_random_req(g);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant();
        int h0;
        int n;
        h0 = hs_count;
        n  = 0;
        while (hs_count == h0 && n < 50) begin
            step();
            n++;
        end
        chk("grant_timeout", int'(hs_count == h0), 0);
    endtask

    task automatic wait_idle();
        int n;
        bit any;
        n = 0;
        forever begin
            any = 0;
            for (int i = 0; i < N; i++) any |= pend_valid[i];
            if ((!model_busy && !any && sb.size() == 0) || n >= 300) break;
            step();
            n++;
        end
        chk("idle_timeout", int'(n >= 300), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_req_ready"},  int'(req_ready),  0);
        chk({tag, "_rsp_valid"},  int'(rsp_valid),  0);
        chk({tag, "_rsp_id"},     int'(rsp_id),     0);
        chk({tag, "_rsp_op"},     int'(rsp_op),     0);
        chk({tag, "_rsp_result"}, int'(rsp_result), 0);
        chk({tag, "_rsp_div0"},   int'(rsp_div0),   0);
        chk({tag, "_busy"},       int'(busy),       0);
    endtask

    // Monitor: owns rsp_ready, pops the scoreboard on each new response.
    initial begin
        bit   prev_valid;
        exp_t cur;
        logic [IW-1:0]  s_id;
        logic [1:0]     s_op;
        logic [2*W-1:0] s_res;
        logic           s_d0;
        prev_valid = 0;
        rsp_ready  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = bp_mode ? 1'b0 : ($urandom_range(0, 9) < 7);
            @(negedge clk);
            if (!n_rst) begin
                prev_valid = 0;
            end else if (rsp_valid) begin
                chk("req_ready_during_rsp", int'(req_ready), 0);
                if (!prev_valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_rsp", 1, 0);
                    end else begin
                        cur = sb.pop_front();
                        $display("[TB] rsp id=%0d op=%0d result=%0d div0=%0b", rsp_id, rsp_op,
                                 int'($signed(rsp_result)), rsp_div0);
                        chk("rsp_id", int'(rsp_id), cur.id);
                        chk("rsp_op", int'(rsp_op), cur.op);
                        chk("rsp_result", int'($signed(rsp_result)), cur.res);
                        chk("rsp_div0", int'(rsp_div0), cur.d0);
                        chk("latency", cyc - cur.hs_cyc, 2);
                    end
                end else begin
                    chk("stable_id", int'(rsp_id), int'(s_id));
                    chk("stable_op", int'(rsp_op), int'(s_op));
                    chk("stable_result", int'(rsp_result), int'(s_res));
                    chk("stable_div0", int'(rsp_div0), int'(s_d0));
                end
                s_id  = rsp_id;
                s_op  = rsp_op;
                s_res = rsp_result;
                s_d0  = rsp_div0;
                if (rsp_ready) begin
                    accept_cyc = cyc;
                    rsp_count++;
                    prev_valid = 0;
                end else begin
                    prev_valid = 1;
                end
            end else begin
                prev_valid = 0;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int n;
        bit any;
        for (int i = 0; i < N; i++) begin
            pend_valid[i] = 1'b0;
            pend_op[i]    = '0;
            pend_a[i]     = '0;
            pend_b[i]     = '0;
            wait_cnt[i]   = 0;
        end
        n_rst     = 1'b0;
        req_valid = '1;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        #1;
        check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        n_rst = 1'b1;

        // single requester add with latency check
        set_req(1, 0, 100, 27);
        wait_grant();
        wait_idle();
        // wide-result corners and divide by zero
        set_req(2, 2, -128, -128);
        wait_grant();
        wait_idle();
        set_req(0, 3, -128, -1);
        wait_grant();
        wait_idle();
        set_req(3, 3, 55, 0);
        wait_grant();
        wait_idle();

        // backpressure: rsp_ready low for 5 cycles while another requester waits
        bp_mode = 1;
        set_req(3, 1, -100, 28);
        wait_grant();
        set_req(0, 0, 5, 6);
        repeat (7) step();
        bp_mode = 0;
        wait_idle();

        // reset while the ALU is executing
        set_req(2, 0, 1, 2);
        wait_grant();
        n_rst     = 1'b0;
        req_valid = '1;
        #1;
        check_outputs_zero("midreset");
        flushed += sb.size();
        sb.delete();
        model_busy = 0;
        model_ptr  = 0;
        for (int i = 0; i < N; i++) begin
            pend_valid[i] = 1'b0;
            wait_cnt[i]   = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;

        // all requesters continuously valid right after reset
        auto_refill = 1;
        for (int i = 0; i < N; i++) new_random_req(i);
        start = grant_log.size();
        n = 0;
        while (grant_log.size() < start + 5 && n < 100) begin
            step();
            n++;
        end
        auto_refill = 0;
        chk("rr_collect_timeout", int'(grant_log.size() < start + 5), 0);
        for (int j = 0; j < 5; j++) begin
            if (start + j < grant_log.size()) chk("rr_order", grant_log[start + j], j % N);
        end
        for (int i = 0; i < N; i++) pend_valid[i] = 1'b0;
        wait_idle();

        // random traffic with occasional withdrawal
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend_valid[i] && $urandom_range(0, 3) == 0) new_random_req(i);
                else if (pend_valid[i] && $urandom_range(0, 49) == 0) begin
                    pend_valid[i] = 1'b0;
                    wait_cnt[i]   = 0;
                end
            end
            step();
        end
        wait_idle();
        repeat (4) step();

        chk("scoreboard_empty", sb.size(), 0);
        chk("rsp_count", rsp_count, hs_count - flushed);
        any = 0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
